clk_div_multi: RTL and testbench

- Parametrised multi-channel clock divider that runs from one fabric clock, normally a 100 MHz MMCM output after its BUFG.
- Each channel produces a registered divided-clock waveform and a one-cycle clock-enable pulse.
- The divisor of each channel is programmable at runtime and takes effect glitch-free at a period boundary.
- A lock FSM reports when all channels are stable, replacing fixed MMCM outputs for low-rate peripheral timing (UART, PS/2, VGA pixel enables).

---
 rtl/clk_div_multi.sv | 152 +++++++++++++++
 tb/tb_clk_div_multi.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable clock divider with lock indication.
// Each channel has a registered divided-clock waveform and a one-cycle enable
// pulse. Divisor updates are deferred to the period boundary so that no runt
// pulse is produced.
// Optional build macro CLK_DIV_MULTI_PHASE_EN adds per-channel phase offsets
// that are loaded into the counters on sync.
//
// Lock FSM:
//   state    | meaning
//   UNLOCKED | every channel stopped (N=0), nothing to lock to
//   SETTLING | divisor or sync changed recently, counting down lcnt
//   LOCKED   | all divisors applied and settle time elapsed
module clk_div_multi #(
  parameter int CHANNELS    = 4,
  parameter int DIV_WIDTH   = 8,
  parameter int DIV_DEFAULT = 2,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CHANNELS-1:0]  div_wr,
  input  logic [DIV_WIDTH-1:0] div_data,
  input  logic                 sync,
`ifdef CLK_DIV_MULTI_PHASE_EN
  input  logic [CHANNELS-1:0]  phase_wr,
  input  logic [DIV_WIDTH-1:0] phase_data,
`endif
  output logic [CHANNELS-1:0]  clk_out,
  output logic [CHANNELS-1:0]  clk_en,
  output logic                 locked
);

  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [DIV_WIDTH-1:0] DIV_RST  = DIV_WIDTH'(DIV_DEFAULT);
  localparam logic [LW-1:0]        LCNT_RST = LW'(LOCK_CYCLES);

  typedef enum logic [1:0] {UNLOCKED, SETTLING, LOCKED} lock_state_t;

  logic [DIV_WIDTH-1:0] cnt      [CHANNELS];
  logic [DIV_WIDTH-1:0] div      [CHANNELS];
  logic [DIV_WIDTH-1:0] pend     [CHANNELS];
  logic [DIV_WIDTH:0]   half     [CHANNELS];
  logic [DIV_WIDTH-1:0] sync_div [CHANNELS];
  logic [DIV_WIDTH-1:0] sync_cnt [CHANNELS];
  logic [CHANNELS-1:0]  pend_vld;
  logic [CHANNELS-1:0]  stopped;
  logic [CHANNELS-1:0]  wrap;

  lock_state_t    state, state_nxt;
  logic [LW-1:0]  lcnt, lcnt_nxt;

`ifdef CLK_DIV_MULTI_PHASE_EN
  logic [DIV_WIDTH-1:0] phase [CHANNELS];

  // Phase offset registers, only consulted on sync.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (!rst_n)           phase[i] <= '0;
      else if (phase_wr[i]) phase[i] <= phase_data;
    end
  end
`endif

  // Per-channel decode: wrap point, high-time threshold, divisor/count loaded by sync.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      stopped[i]  = (div[i] == '0);
      wrap[i]     = !stopped[i] && (cnt[i] == div[i] - DIV_WIDTH'(1));
      half[i]     = ({1'b0, div[i]} + (DIV_WIDTH+1)'(1)) >> 1;
      sync_div[i] = div_wr[i] ? div_data : (pend_vld[i] ? pend[i] : div[i]);
      sync_cnt[i] = '0;
`ifdef CLK_DIV_MULTI_PHASE_EN
      if (phase[i] >= sync_div[i])
        sync_cnt[i] = (sync_div[i] == '0) ? '0 : sync_div[i] - DIV_WIDTH'(1);
      else
        sync_cnt[i] = phase[i];
`endif
    end
  end

  // Channel counters, pending divisor handling and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i]  <= '0;
        div[i]  <= DIV_RST;
        pend[i] <= DIV_RST;
      end
      pend_vld <= '0;
      clk_out  <= '0;
      clk_en   <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        clk_en[i]  <= !stopped[i] && (cnt[i] == '0);
        clk_out[i] <= !stopped[i] && ({1'b0, cnt[i]} < half[i]);
        if (div_wr[i]) pend[i] <= div_data;
        if (sync) begin
          cnt[i]      <= sync_cnt[i];
          div[i]      <= sync_div[i];
          pend_vld[i] <= 1'b0;
        end else begin
          if (stopped[i] || wrap[i]) cnt[i] <= '0;
          else                       cnt[i] <= cnt[i] + DIV_WIDTH'(1);
          // A stopped channel picks up its new divisor on the next cycle;
          // a running one only at its wrap so the current period completes.
          if ((stopped[i] || wrap[i]) && pend_vld[i]) begin
            div[i]      <= pend[i];
            pend_vld[i] <= div_wr[i];
          end else if (div_wr[i]) begin
            pend_vld[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SETTLING;
      lcnt  <= LCNT_RST;
    end else begin
      state <= state_nxt;
      lcnt  <= lcnt_nxt;
    end
  end

  // Lock FSM next state: any write or sync restarts settling; countdown holds while divisors are pending.
  always_comb begin
    state_nxt = state;
    lcnt_nxt  = lcnt;
    if ((|div_wr) || sync) begin
      state_nxt = SETTLING;
      lcnt_nxt  = LCNT_RST;
    end else begin
      case (state)
        SETTLING: begin
          if (&stopped && !(|pend_vld)) begin
            state_nxt = UNLOCKED;
          end else if (!(|pend_vld)) begin
            if (lcnt == LW'(1)) state_nxt = LOCKED;
            else                lcnt_nxt  = lcnt - LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed scenarios for clk_div_multi (4 channels, defaults).
// Stimulus pushes per-cycle expectations into a scoreboard queue; a monitor
// on the falling edge pops the entries for the current cycle and compares.
module tb_clk_div_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] div_wr;
  logic [7:0] div_data;
  logic       sync;
  logic [3:0] clk_out;
  logic [3:0] clk_en;
  logic       locked;
`ifdef CLK_DIV_MULTI_PHASE_EN
  logic [3:0] phase_wr   = '0;
  logic [7:0] phase_data = '0;
`endif

  clk_div_multi #(.CHANNELS(4), .DIV_WIDTH(8), .DIV_DEFAULT(2), .LOCK_CYCLES(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .div_wr   (div_wr),
    .div_data (div_data),
    .sync     (sync),
`ifdef CLK_DIV_MULTI_PHASE_EN
    .phase_wr   (phase_wr),
    .phase_data (phase_data),
`endif
    .clk_out  (clk_out),
    .clk_en   (clk_en),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    logic [3:0] m;
    logic [3:0] o;
    logic [3:0] e;
    bit       lm;
    bit       l;
    string    nm;
  } exp_t;

  exp_t sbq[$];
  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  // Cycle index: observation cycle k is the state after the k-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation registered for the current cycle.
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == cyc) begin
        if (sbq[i].m != 4'b0) begin
          total++;
          if ((clk_out & sbq[i].m) != (sbq[i].o & sbq[i].m)) begin
            bad++;
            $display("FAIL %s clk_out cyc=%0d got=%b want=%b mask=%b",
                     sbq[i].nm, cyc, clk_out, sbq[i].o, sbq[i].m);
          end
          total++;
          if ((clk_en & sbq[i].m) != (sbq[i].e & sbq[i].m)) begin
            bad++;
            $display("FAIL %s clk_en cyc=%0d got=%b want=%b mask=%b",
                     sbq[i].nm, cyc, clk_en, sbq[i].e, sbq[i].m);
          end
        end
        if (sbq[i].lm) begin
          total++;
          if (locked !== sbq[i].l) begin
            bad++;
            $display("FAIL %s locked cyc=%0d got=%b want=%b", sbq[i].nm, cyc, locked, sbq[i].l);
          end
        end
        sbq.delete(i);
      end
    end
  end

  // Expected waveform of a channel with divisor n whose phase-0 cycle is at m=0.
  function automatic bit wo(int n, int m);
    if (n == 0) return 1'b0;
    return (m % n) < ((n + 1) / 2);
  endfunction

  function automatic bit we(int n, int m);
    if (n == 0) return 1'b0;
    return (m % n) == 0;
  endfunction

  task automatic expv(int c, logic [3:0] m, logic [3:0] o, logic [3:0] e, bit lm, bit l, string nm);
    exp_t x;
    x.cyc = c; x.m = m; x.o = o; x.e = e; x.lm = lm; x.l = l; x.nm = nm;
    sbq.push_back(x);
  endtask

  // Full-mask expectation from per-channel (divisor, phase-0 cycle) pairs.
  task automatic push_wave(int c, int n0, int b0, int n1, int b1, int n2, int b2,
                           int n3, int b3, bit l, string nm);
    logic [3:0] o, e;
    o = {wo(n3, c - b3), wo(n2, c - b2), wo(n1, c - b1), wo(n0, c - b0)};
    e = {we(n3, c - b3), we(n2, c - b2), we(n1, c - b1), we(n0, c - b0)};
    expv(c, 4'hF, o, e, 1'b1, l, nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_to(int c);
    while (cyc < c) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  int r, t, a1, u, v, s, a, b, p;

  initial begin
    rst_n = 1'b0; div_wr = '0; div_data = '0; sync = 1'b0;
    repeat (3) tick();

    // Reset state, then default N=2 on every channel and lock after 16 cycles.
    rst_n = 1'b1;
    r = cyc;
    expv(r, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, "reset_state");
    for (int c = r + 1; c <= r + 20; c++)
      push_wave(c, 2, r + 1, 2, r + 1, 2, r + 1, 2, r + 1, c >= r + 16, "default_n2");
    wait_to(r + 20);

    // Channel 1 to N=5 mid-period; applied at the old wrap.
    t = cyc;
    a1 = t + 3;
    div_wr = 4'b0010; div_data = 8'd5;
    for (int c = t + 1; c <= t + 30; c++) begin
      if (c <= t + 2)
        push_wave(c, 2, r + 1, 2, r + 1, 2, r + 1, 2, r + 1, 1'b0, "ch1_to5");
      else
        push_wave(c, 2, r + 1, 5, a1, 2, r + 1, 2, r + 1, c >= t + 18, "ch1_to5");
    end
    tick();
    div_wr = '0;
    wait_to(t + 30);

    // Channel 2 stopped, then restarted with N=3.
    u = cyc;
    v = u + 10;
    div_wr = 4'b0100; div_data = 8'd0;
    for (int c = u + 1; c <= v + 25; c++) begin
      if (c <= u + 2)
        push_wave(c, 2, r + 1, 5, a1, 2, r + 1, 2, r + 1, 1'b0, "ch2_stop");
      else if (c <= v + 2)
        push_wave(c, 2, r + 1, 5, a1, 0, 0, 2, r + 1, 1'b0, "ch2_stop");
      else
        push_wave(c, 2, r + 1, 5, a1, 3, v + 3, 2, r + 1, c >= v + 18, "ch2_restart");
    end
    tick();
    div_wr = '0;
    wait_to(v);
    div_wr = 4'b0100; div_data = 8'd3;
    tick();
    div_wr = '0;
    wait_to(v + 25);

    // sync together with a write of N=4 to channel 0.
    s = cyc;
    sync = 1'b1; div_wr = 4'b0001; div_data = 8'd4;
    push_wave(s + 1, 2, r + 1, 5, a1, 3, v + 3, 2, r + 1, 1'b0, "sync_pre");
    for (int c = s + 2; c <= s + 25; c++)
      push_wave(c, 4, s + 2, 5, s + 2, 3, s + 2, 2, s + 2, c >= s + 17, "sync_align");
    tick();
    sync = 1'b0; div_wr = '0;
    wait_to(s + 25);

    // Stop every channel: UNLOCKED, then N=1 on channel 3.
    a = cyc;
    b = a + 30;
    div_wr = 4'b1111; div_data = 8'd0;
    push_wave(a + 1, 4, s + 2, 5, s + 2, 3, s + 2, 2, s + 2, 1'b0, "all_stop_pre");
    for (int c = a + 2; c <= a + 7; c++)
      expv(c, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, "all_stop_lock");
    for (int c = a + 8; c <= b + 2; c++)
      push_wave(c, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, "all_stopped");
    for (int c = b + 3; c <= b + 25; c++)
      push_wave(c, 0, 0, 0, 0, 0, 0, 1, b + 3, c >= b + 18, "ch3_n1");
    tick();
    div_wr = '0;
    wait_to(b);
    div_wr = 4'b1000; div_data = 8'd1;
    tick();
    div_wr = '0;
    wait_to(b + 25);

    // One-cycle reset while a write to channel 0 is still pending.
    p = cyc;
    div_wr = 4'b0001; div_data = 8'd7;
    push_wave(p + 1, 0, 0, 0, 0, 0, 0, 1, b + 3, 1'b0, "rst_pend_pre");
    expv(p + 2, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, "rst_pend_zero");
    for (int c = p + 3; c <= p + 24; c++)
      push_wave(c, 2, p + 3, 2, p + 3, 2, p + 3, 2, p + 3, c >= p + 18, "rst_pend_default");
    tick();
    div_wr = '0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_to(p + 26);

    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
